// File: rtl/flash_burst_reader_pkg.sv
// Shared types and constants for the flash burst reader and its phase counter.
package flash_burst_reader_pkg;
  localparam int FLASH_ADDR_W = 23;

  typedef logic [31:0]             Word_t;
  typedef logic                    Bit_t;
  typedef logic [15:0]             Half_t;
  typedef logic [FLASH_ADDR_W-1:0] Flash_addr_t;

  typedef enum logic [2:0] {
    INIT_CMD,
    INIT_HOLD,
    IDLE,
    SETUP,
    READ_LO,
    READ_HI,
    OUTPUT
  } state_t;

  localparam Half_t FLASH_CMD_READ_ARRAY = 16'h00FF;
endpackage

// File: rtl/flash_burst_reader_wait.sv
// Loadable down-counter: done is high on the last cycle of a WAIT_CYCLES-long phase.
module flash_wait_counter
  import flash_burst_reader_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);
  localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES);

  logic [3:0] count;

  // Reset value equals the load value so INIT_CMD is timed straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= LOAD_VAL;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != 4'd1) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd1);
endmodule

// File: rtl/flash_burst_reader.sv
// Burst reader for a 16-bit asynchronous NOR flash: issues read-array after reset, then returns 32-bit words.
module flash_burst_reader
  import flash_burst_reader_pkg::*;
#(
  parameter  int WAIT_CYCLES = 3,
  parameter  int BURST_MAX   = 8,
  parameter  int ADDR_W      = 23,
  localparam int LEN_W       = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [ADDR_W-1:0] flash_a,
  inout  wire  [15:0]       flash_d,
  output logic              flash_rp_n,
  output logic              flash_vpen,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_byte_n
);
  state_t             state, state_next;
  logic [ADDR_W-1:0]  ptr;
  logic [LEN_W-1:0]   remaining;
  Word_t              data;
  logic               valid;
  logic               load, phase_done, accept, hs;
  logic               ce_n_c, oe_n_c, we_n_c, drive_c;
  logic               unused_addr_bits;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) return LEN_W'(1);
    if (len > LEN_W'(BURST_MAX)) return LEN_W'(BURST_MAX);
    return len;
  endfunction

  flash_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .done (phase_done)
  );

  assign accept           = (state == IDLE) && req_valid;
  assign hs               = valid && rsp_ready;
  assign unused_addr_bits = ^req_addr[1:0];

  always_comb begin
    state_next = state;
    ce_n_c     = 1'b1;
    oe_n_c     = 1'b1;
    we_n_c     = 1'b1;
    drive_c    = 1'b0;
    case (state)
      INIT_CMD: begin
        ce_n_c  = 1'b0;
        we_n_c  = 1'b0;
        drive_c = 1'b1;
        if (phase_done) state_next = INIT_HOLD;
      end
      INIT_HOLD: begin
        ce_n_c     = 1'b0;
        drive_c    = 1'b1;
        state_next = IDLE;
      end
      IDLE: begin
        if (req_valid) state_next = SETUP;
      end
      SETUP: begin
        ce_n_c     = 1'b0;
        state_next = READ_LO;
      end
      READ_LO: begin
        ce_n_c = 1'b0;
        oe_n_c = 1'b0;
        if (phase_done) state_next = READ_HI;
      end
      READ_HI: begin
        ce_n_c = 1'b0;
        oe_n_c = 1'b0;
        if (phase_done) state_next = OUTPUT;
      end
      OUTPUT: begin
        ce_n_c = 1'b0;
        if (hs) state_next = (remaining == LEN_W'(1)) ? IDLE : SETUP;
      end
      default: state_next = INIT_CMD;
    endcase
    load = (state_next != state);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT_CMD;
    else      state <= state_next;
  end

  // Datapath: pointer, word count and the response word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      remaining <= '0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      if (accept) begin
        ptr       <= {req_addr[ADDR_W:2], 1'b0};
        remaining <= clamp_len(req_len);
      end
      if (state == READ_LO && phase_done) begin
        data[15:0] <= flash_d;
        ptr        <= ptr + 1'b1;
      end
      if (state == READ_HI && phase_done) begin
        data[31:16] <= flash_d;
        ptr         <= ptr + 1'b1;
      end
      if (hs) begin
        valid     <= 1'b0;
        remaining <= remaining - 1'b1;
      end else if (state == OUTPUT) begin
        valid <= 1'b1;
      end
    end
  end

  // Strobes are gated by rst so an abort releases the bus in the same cycle.
  assign flash_ce_n   = ce_n_c | ~rst;
  assign flash_oe_n   = oe_n_c | ~rst;
  assign flash_we_n   = we_n_c | ~rst;
  assign flash_d      = (drive_c && rst) ? FLASH_CMD_READ_ARRAY : 16'hzzzz;
  assign flash_a      = ptr;
  assign flash_rp_n   = 1'b1;
  assign flash_vpen   = 1'b0;
  assign flash_byte_n = 1'b1;

  assign req_ready = rst && (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = valid;
  assign rsp_data  = data;
  assign rsp_last  = valid && (remaining == LEN_W'(1));
endmodule

// File: tb/tb_flash_burst_reader.sv
// Randomized bench: fake flash returns halfword[i]=i, bursts are compared against a queue-based word model.
module tb_flash_burst_reader;
  localparam int W  = 3;
  localparam int BM = 8;
  localparam int AW = 23;
  localparam int LW = $clog2(BM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW:0]   req_addr;
  logic [LW-1:0] req_len;
  logic          rsp_valid, rsp_ready, rsp_last, busy;
  logic [31:0]   rsp_data;
  logic [AW-1:0] flash_a;
  wire  [15:0]   flash_d;
  logic          flash_rp_n, flash_vpen, flash_ce_n, flash_oe_n, flash_we_n, flash_byte_n;

  int n_checks = 0;
  int n_pass   = 0;

  flash_burst_reader #(.WAIT_CYCLES(W), .BURST_MAX(BM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .flash_a(flash_a), .flash_d(flash_d),
    .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen), .flash_ce_n(flash_ce_n),
    .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n), .flash_byte_n(flash_byte_n)
  );

  always #5 clk = ~clk;

  // Fake flash: the content of halfword address i is i (low 16 bits).
  assign flash_d = (!flash_oe_n && !flash_ce_n) ? flash_a[15:0] : 16'hzzzz;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_init();
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check_val("init_we_n", flash_we_n, 0);
      check_val("init_ce_n", flash_ce_n, 0);
      check_val("init_oe_n", flash_oe_n, 1);
      check_val("init_cmd", flash_d, 16'h00FF);
      check_val("init_ready", req_ready, 0);
    end
    @(negedge clk);
    check_val("hold_we_n", flash_we_n, 1);
    check_val("hold_ce_n", flash_ce_n, 0);
    check_val("hold_cmd", flash_d, 16'h00FF);
    check_val("hold_ready", req_ready, 0);
    @(negedge clk);
    check_val("idle_ready", req_ready, 1);
    check_val("idle_ce_n", flash_ce_n, 1);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 0);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_rsp_last"}, rsp_last, 0);
    check_val({tag, "_rsp_data"}, rsp_data, 0);
    check_val({tag, "_busy"}, busy, 1);
    check_val({tag, "_ce_n"}, flash_ce_n, 1);
    check_val({tag, "_oe_n"}, flash_oe_n, 1);
    check_val({tag, "_we_n"}, flash_we_n, 1);
    check_val({tag, "_flash_a"}, flash_a, 0);
  endtask

  // mode 0: always ready, 1: toggle ready every cycle, 2: random ready
  task automatic run_burst(input logic [AW:0] addr, input logic [LW-1:0] len,
                           input int mode, output logic [31:0] first_word);
    logic [31:0]   exp_q[$];
    logic [31:0]   exp_w, held_d;
    logic          held_l, stalled;
    longint        p;
    int            n, k, last_hs, got;
    n = (len == 0) ? 1 : ((int'(len) > BM) ? BM : int'(len));
    p = (longint'(addr) / 4) * 2;
    for (int i = 0; i < n; i++) begin
      exp_w = {16'((p + 1) % (longint'(1) << AW)), 16'(p % (longint'(1) << AW))};
      exp_q.push_back(exp_w);
      p = (p + 2) % (longint'(1) << AW);
    end
    first_word = '0;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    rsp_ready = (mode == 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0; last_hs = 0; got = 0; stalled = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (got < n && k < 2000) begin
      @(negedge clk);
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ~rsp_ready;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      check_val("oe_we_excl", !flash_oe_n && !flash_we_n, 0);
      if (rsp_valid) begin
        if (stalled) begin
          check_val("stall_data", rsp_data, held_d);
          check_val("stall_last", rsp_last, held_l);
          check_val("stall_ce_n", flash_ce_n, 0);
          check_val("stall_oe_n", flash_oe_n, 1);
        end else begin
          check_val("latency", k - last_hs, 2 * W + 2);
        end
        if (rsp_ready) begin
          exp_w = exp_q.pop_front();
          if (got == 0) first_word = rsp_data;
          check_val("rsp_data", rsp_data, exp_w);
          check_val("rsp_last", rsp_last, got == n - 1);
          got++;
          last_hs = k + 1;
          stalled = 1'b0;
        end else if (!stalled) begin
          held_d  = rsp_data;
          held_l  = rsp_last;
          stalled = 1'b1;
        end
      end
      @(posedge clk);
      k++;
    end
    check_val("burst_words", got, n);
    @(negedge clk);
    check_val("end_rsp_valid", rsp_valid, 0);
    check_val("end_busy", busy, 0);
    check_val("end_ce_n", flash_ce_n, 1);
    check_val("end_ready", req_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int          k, words;
    logic        found;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    check_val("rst_rp_n", flash_rp_n, 1);
    check_val("rst_vpen", flash_vpen, 0);
    check_val("rst_byte_n", flash_byte_n, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    check_init();

    run_burst(24'h000010, 4'd1, 0, w);
    check_val("single_word", w, 32'h00090008);
    run_burst(24'h000000, 4'd4, 1, w);
    check_val("burst4_first", w, 32'h00010000);
    run_burst(24'hFFFFFC, 4'd2, 2, w);
    check_val("wrap_first", w, 32'hFFFFFFFE);
    run_burst(24'h000123, 4'd0, 0, w);
    run_burst(24'h000400, 4'd15, 2, w);
    run_burst(24'h000800, 4'd9, 1, w);

    // Abort during READ_HI of the second word of a 4-word burst.
    req_valid = 1'b1; req_addr = '0; req_len = 4'd4; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0; words = 0; found = 1'b0;
    while (!found && k < 200) begin
      @(negedge clk);
      if (words >= 1 && !flash_oe_n && flash_a[0]) found = 1'b1;
      else if (rsp_valid && rsp_ready) words++;
      k++;
    end
    check_val("midrst_found", found, 1);
    rst = 1'b0;
    #1 check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("midrst_no_valid", rsp_valid, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    check_init();

    for (int t = 0; t < 12; t++) begin
      run_burst(25'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
